// File: rtl/argmax_classifier.sv
// Argmax output stage: collects one frame of unsigned neuron results over a
// valid/ready stream and presents the winning class, its score and a frame
// length error flag on a held output handshake.
module argmax_classifier #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [IDX_W-1:0]  out_class_o,
  output logic [DATA_W-1:0] out_score_o,
  output logic              out_err_o
);

  localparam logic [IDX_W-1:0] LastBeat = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [0:0] {StCollect, StOutput} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   best_q, best_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                out_valid_q, out_valid_d;
  logic [IDX_W-1:0]    out_class_q, out_class_d;
  logic [DATA_W-1:0]   out_score_q, out_score_d;
  logic                out_err_q, out_err_d;

  logic                accept;
  logic                take;
  logic                final_slot;
  logic [DATA_W-1:0]   new_best;
  logic [IDX_W-1:0]    new_idx;

  assign in_ready_o = (state_q == StCollect) & ~rst_i;
  assign accept     = in_valid_i & in_ready_o;
  // First beat loads unconditionally; later beats replace only on strictly greater.
  assign take       = (count_q == '0) | (in_data_i > best_q);
  assign final_slot = (count_q == LastBeat);
  assign new_best   = take ? in_data_i : best_q;
  assign new_idx    = take ? count_q : idx_q;

  // Next-state: running compare while collecting, hold result until consumed.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    best_d      = best_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_score_d = out_score_q;
    out_err_d   = out_err_q;
    unique case (state_q)
      StCollect: begin
        if (accept) begin
          best_d = new_best;
          idx_d  = new_idx;
          if (final_slot || in_last_i) begin
            state_d     = StOutput;
            out_valid_d = 1'b1;
            out_class_d = new_idx;
            out_score_d = new_best;
            // Short frame or missing in_last both flag an error.
            out_err_d   = in_last_i ^ final_slot;
          end else begin
            count_d = count_q + IDX_W'(1);
          end
        end
      end
      StOutput: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          count_d     = '0;
          state_d     = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  // State register with asynchronous reset discarding any partial frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StCollect;
      count_q     <= '0;
      best_q      <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_score_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      best_q      <= best_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_score_q <= out_score_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_class_o = out_class_q;
  assign out_score_o = out_score_q;
  assign out_err_o   = out_err_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Bench for argmax_classifier: directed frames from the datasheet examples plus
// random frames checked against a queue-based argmax reference.
module tb_argmax_classifier;

  localparam int DW = 64;
  localparam int NC = 10;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_class;
  logic [DW-1:0] out_score;
  logic          out_err;

  int n_cmp = 0;
  int n_bad = 0;

  argmax_classifier #(
    .DATA_W     (DW),
    .NUM_CLASSES(NC)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_class_o(out_class),
    .out_score_o(out_score),
    .out_err_o  (out_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: find the maximum value, then the first index holding it.
  task automatic ref_model(input logic [DW-1:0] d[$], input bit last_final,
                           output logic [IW-1:0] cls, output logic [DW-1:0] sc,
                           output bit err);
    logic [DW-1:0] mx;
    mx = 0;
    foreach (d[i]) if (d[i] > mx) mx = d[i];
    cls = 0;
    for (int i = d.size() - 1; i >= 0; i--) if (d[i] == mx) cls = IW'(i);
    sc  = mx;
    err = (d.size() < NC) || !last_final;
  endtask

  // Present one beat at a negedge and hold it until it is taken at a posedge.
  task automatic send_beat(input logic [DW-1:0] v, input bit last);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    in_last  = last;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check_eq("beat_timeout", 64'(in_ready), 64'd1);
    check_eq("ov_pre", 64'(out_valid), 64'd0);
    @(posedge clk);
  endtask

  task automatic run_frame(input string tag, input logic [DW-1:0] d[$], input bit last_final,
                           input logic [IW-1:0] e_cls, input logic [DW-1:0] e_sc,
                           input bit e_err, input int hold, input bit gaps);
    for (int i = 0; i < d.size(); i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
      end
      send_beat(d[i], (i == d.size() - 1) ? last_final : 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_eq({tag, ":valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, ":class"}, 64'(out_class), 64'(e_cls));
    check_eq({tag, ":score"}, out_score, e_sc);
    check_eq({tag, ":err"}, 64'(out_err), 64'(e_err));
    // Stall the consumer while junk beats are offered; nothing may move.
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      in_last  = 1'($urandom);
      @(negedge clk);
      check_eq({tag, ":hold_rdy"}, 64'(in_ready), 64'd0);
      check_eq({tag, ":hold_ov"}, 64'(out_valid), 64'd1);
      check_eq({tag, ":hold_cls"}, 64'(out_class), 64'(e_cls));
      check_eq({tag, ":hold_sc"}, out_score, e_sc);
      check_eq({tag, ":hold_err"}, 64'(out_err), 64'(e_err));
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, ":ov_drop"}, 64'(out_valid), 64'd0);
    check_eq({tag, ":rdy_back"}, 64'(in_ready), 64'd1);
    check_eq({tag, ":cls_kept"}, 64'(out_class), 64'(e_cls));
    check_eq({tag, ":sc_kept"}, out_score, e_sc);
  endtask

  initial begin
    logic [DW-1:0] q[$];
    logic [IW-1:0] e_cls;
    logic [DW-1:0] e_sc;
    bit            e_err;
    bit            lf;
    int            len;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #12;
    check_eq("rst_rdy", 64'(in_ready), 64'd0);
    check_eq("rst_ov", 64'(out_valid), 64'd0);
    check_eq("rst_cls", 64'(out_class), 64'd0);
    check_eq("rst_sc", out_score, 64'd0);
    check_eq("rst_err", 64'(out_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_rdy", 64'(in_ready), 64'd1);

    q = '{64'd5, 64'd9, 64'd3, 64'd9, 64'd1, 64'd0, 64'd2, 64'd7, 64'd4, 64'd8};
    run_frame("t1", q, 1'b1, 4'd1, 64'd9, 1'b0, 0, 1'b0);

    q = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    run_frame("t2", q, 1'b1, 4'd0, 64'd0, 1'b0, 1, 1'b0);

    q = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8, 64'd9,
          64'hFFFF_FFFF_FFFF_FFFF};
    run_frame("t3", q, 1'b1, 4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 1'b1);

    q = '{64'd2, 64'd6, 64'd6, 64'd1};
    run_frame("t4a", q, 1'b1, 4'd1, 64'd6, 1'b1, 0, 1'b0);

    q = '{64'd4, 64'd2, 64'd8, 64'd8, 64'd1, 64'd0, 64'd3, 64'd5, 64'd6, 64'd7};
    run_frame("t4b", q, 1'b0, 4'd2, 64'd8, 1'b1, 0, 1'b0);

    q = '{64'd10, 64'd20, 64'd30, 64'd40, 64'd50, 64'd60, 64'd70, 64'd80, 64'd90, 64'd15};
    run_frame("t5", q, 1'b1, 4'd8, 64'd90, 1'b0, 20, 1'b0);

    // Reset mid-frame: a large partial best must not leak into the next frame.
    send_beat(64'd1, 1'b0);
    send_beat(64'd2, 1'b0);
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_beat(64'd3, 1'b0);
    send_beat(64'd4, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check_eq("t6_rst_rdy", 64'(in_ready), 64'd0);
    check_eq("t6_rst_ov", 64'(out_valid), 64'd0);
    check_eq("t6_rst_cls", 64'(out_class), 64'd0);
    check_eq("t6_rst_sc", out_score, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    q = '{64'd3, 64'd1, 64'd4, 64'd1, 64'd5, 64'd9, 64'd2, 64'd6, 64'd5, 64'd3};
    run_frame("t6", q, 1'b1, 4'd5, 64'd9, 1'b0, 0, 1'b0);

    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, NC);
      lf  = (len < NC) ? 1'b1 : 1'($urandom);
      q.delete();
      for (int i = 0; i < len; i++) begin
        if (f[0]) q.push_back(64'($urandom_range(0, 3)));
        else      q.push_back({$urandom, $urandom});
      end
      ref_model(q, lf, e_cls, e_sc, e_err);
      run_frame($sformatf("rnd%0d", f), q, lf, e_cls, e_sc, e_err, $urandom_range(0, 3), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
